// File: rtl/vga_rx_monitor.sv
// vga_rx_monitor
// Receive-side monitor for a VGA stream (640x480@60 by default). It samples
// the generator's syncs and colour on the pixel clock, locks a pair of
// position counters to the sync edges, reports every visible pixel with its
// coordinates, flags horizontal/vertical timing errors and produces a
// per-frame colour checksum for clean frames.
//
// Ports:
//   clk_25_175  in   pixel clock
//   rst         in   asynchronous reset, active-high
//   hsync       in   horizontal sync from the generator
//   vsync       in   vertical sync from the generator
//   rgb         in   12-bit colour {r,g,b}, 4 bits each
//   pix_valid   out  pix_x/pix_y/pix_rgb hold a visible pixel
//   pix_x       out  column of the reported pixel
//   pix_y       out  row of the reported pixel
//   pix_rgb     out  colour of the reported pixel
//   frame_start out  pulse together with pixel (0,0)
//   frame_done  out  pulse together with the last pixel of a clean frame
//   frame_sum   out  checksum of the last clean frame
//   locked      out  monitor is fully locked (horizontal and vertical)
//   h_err       out  one-cycle horizontal timing error pulse
//   v_err       out  one-cycle vertical timing error pulse
//   err_count   out  saturating count of cycles with a timing error
//
// Pipeline: stage 1 registers the pins and advances hc/vc/state so that they
// describe the stage-1 sample; stage 2 registers every pixel/frame/error
// output from the stage-1 sample, giving two clocks from pins to outputs.
// hc/vc are 10 bits wide, so H_TOTAL and V_TOTAL must not exceed 1024.

module vga_rx_monitor #(
    parameter int H_VISIBLE = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_TOTAL   = 800,
    parameter int V_VISIBLE = 480,
    parameter int V_FRONT   = 10,
    parameter int V_TOTAL   = 525,
    parameter int SYNC_POL  = 0
) (
    input  logic        clk_25_175,
    input  logic        rst,
    input  logic        hsync,
    input  logic        vsync,
    input  logic [11:0] rgb,
    output logic        pix_valid,
    output logic [9:0]  pix_x,
    output logic [9:0]  pix_y,
    output logic [11:0] pix_rgb,
    output logic        frame_start,
    output logic        frame_done,
    output logic [15:0] frame_sum,
    output logic        locked,
    output logic        h_err,
    output logic        v_err,
    output logic [7:0]  err_count
);

    localparam int HS = H_VISIBLE + H_FRONT;
    localparam int VS = V_VISIBLE + V_FRONT;

    // A misconfigured line shorter than front porch plus sync pulse would make
    // hc wrap inside the pulse; stretch the counted line so the pulse fits.
    localparam int H_COUNT = (HS + H_SYNC > H_TOTAL) ? (HS + H_SYNC) : H_TOTAL;

    localparam logic [9:0] HS_C   = 10'(HS);
    localparam logic [9:0] VS_C   = 10'(VS);
    localparam logic [9:0] H_LAST = 10'(H_COUNT - 1);
    localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
    localparam logic [9:0] HV_C   = 10'(H_VISIBLE);
    localparam logic [9:0] VV_C   = 10'(V_VISIBLE);
    localparam logic [9:0] X_LAST = 10'(H_VISIBLE - 1);
    localparam logic [9:0] Y_LAST = 10'(V_VISIBLE - 1);
    localparam logic       ACT    = (SYNC_POL != 0) ? 1'b1 : 1'b0;

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        HLOCK  = 2'd1,
        LOCKED = 2'd2
    } state_t;

    state_t      state, state_next;
    logic        hs1, vs1;
    logic [11:0] rgb1;
    logic [9:0]  hc, vc, hc_next, vc_next, hc_nat, vc_nat;
    logic        herr1, verr1, herr_next, verr_next;
    logic        hfall, vfall, h_bad, h_miss, v_bad, v_miss;
    logic        valid1, at_origin, at_last, clean;
    logic [15:0] acc;

    // Edge detection compares the incoming pin against the stage-1 copy, so
    // a "fall" belongs to the sample that is about to enter stage 1. The
    // natural count is where hc/vc would land for that sample with no reload.
    always_comb begin
        hfall  = (hsync == ACT) && (hs1 != ACT);
        vfall  = (vsync == ACT) && (vs1 != ACT);
        hc_nat = (hc == H_LAST) ? 10'd0 : hc + 10'd1;
        if (hc == H_LAST) begin
            vc_nat = (vc == V_LAST) ? 10'd0 : vc + 10'd1;
        end else begin
            vc_nat = vc;
        end
        h_bad  = hfall && (hc_nat != HS_C);
        h_miss = !hfall && (hc_nat == HS_C);
        v_bad  = vfall && !((hc_nat == 10'd0) && (vc_nat == VS_C));
        v_miss = !vfall && (hc_nat == 10'd0) && (vc_nat == VS_C);
    end

    // Lock state machine and counter reloads. In LOCKED the horizontal
    // checks are evaluated after the vertical ones so that a lost hsync
    // (SEARCH) overrides the milder fall back to HLOCK.
    always_comb begin
        state_next = state;
        herr_next  = 1'b0;
        verr_next  = 1'b0;
        hc_next    = hfall ? HS_C : hc_nat;
        vc_next    = vc_nat;
        case (state)
            SEARCH: begin
                if (hfall) begin
                    state_next = HLOCK;
                end
            end
            HLOCK: begin
                if (h_miss) begin
                    herr_next  = 1'b1;
                    state_next = SEARCH;
                end else if (h_bad) begin
                    herr_next  = 1'b1;
                end else if (vfall && (hc_nat == 10'd0)) begin
                    vc_next    = VS_C;
                    state_next = LOCKED;
                end
            end
            LOCKED: begin
                if (vfall) begin
                    vc_next = VS_C;
                end
                if (v_bad || v_miss) begin
                    verr_next  = 1'b1;
                    state_next = HLOCK;
                end
                if (h_bad) begin
                    herr_next  = 1'b1;
                    state_next = HLOCK;
                end
                if (h_miss) begin
                    herr_next  = 1'b1;
                    state_next = SEARCH;
                end
            end
            default: begin
                state_next = SEARCH;
            end
        endcase
    end

    // Stage 1: pin capture plus counters and state for the captured sample.
    // The sync copies reset to the active level so that a sync already
    // active when reset is released is not mistaken for a fresh edge.
    always_ff @(posedge clk_25_175 or posedge rst) begin
        if (rst) begin
            hs1   <= ACT;
            vs1   <= ACT;
            rgb1  <= '0;
            hc    <= '0;
            vc    <= '0;
            state <= SEARCH;
            herr1 <= 1'b0;
            verr1 <= 1'b0;
        end else begin
            hs1   <= hsync;
            vs1   <= vsync;
            rgb1  <= rgb;
            hc    <= hc_next;
            vc    <= vc_next;
            state <= state_next;
            herr1 <= herr_next;
            verr1 <= verr_next;
        end
    end

    always_comb begin
        valid1    = (state == LOCKED) && (hc < HV_C) && (vc < VV_C);
        at_origin = valid1 && (hc == 10'd0) && (vc == 10'd0);
        at_last   = valid1 && (hc == X_LAST) && (vc == Y_LAST);
    end

    // Stage 2: pixel reporting, error pulses and the frame checksum. A frame
    // stays clean only while every stage-1 sample since its (0,0) was LOCKED.
    always_ff @(posedge clk_25_175 or posedge rst) begin
        if (rst) begin
            pix_valid   <= 1'b0;
            pix_x       <= '0;
            pix_y       <= '0;
            pix_rgb     <= '0;
            frame_start <= 1'b0;
            frame_done  <= 1'b0;
            frame_sum   <= '0;
            h_err       <= 1'b0;
            v_err       <= 1'b0;
            err_count   <= '0;
            acc         <= '0;
            clean       <= 1'b0;
        end else begin
            pix_valid   <= valid1;
            pix_x       <= valid1 ? hc : 10'd0;
            pix_y       <= valid1 ? vc : 10'd0;
            pix_rgb     <= valid1 ? rgb1 : 12'd0;
            frame_start <= at_origin;
            frame_done  <= at_last && clean;
            h_err       <= herr1;
            v_err       <= verr1;
            if ((herr1 || verr1) && (err_count != 8'hFF)) begin
                err_count <= err_count + 8'd1;
            end
            if (at_origin) begin
                acc <= {4'b0000, rgb1};
            end else if (valid1) begin
                acc <= acc + {4'b0000, rgb1};
            end
            if (at_origin) begin
                clean <= 1'b1;
            end else if (state != LOCKED) begin
                clean <= 1'b0;
            end
            if (at_last && clean) begin
                frame_sum <= acc + {4'b0000, rgb1};
            end
        end
    end

    assign locked = (state == LOCKED);

endmodule

// File: tb/tb_vga_rx_monitor.sv
// tb_vga_rx_monitor
// Drives a small-geometry VGA generator into vga_rx_monitor and checks its
// pixel reports, frame pulses, checksums, error pulses and lock status.
// Expected pixels are queued when driven and compared when reported.

module tb_vga_rx_monitor;

    localparam int HV  = 16;
    localparam int HF  = 4;
    localparam int HSW = 6;
    localparam int HT  = 32;
    localparam int VV  = 12;
    localparam int VF  = 2;
    localparam int VSW = 2;
    localparam int VT  = 20;
    localparam int HS  = HV + HF;
    localparam int VS  = VV + VF;

    typedef struct {
        logic [9:0]  x;
        logic [9:0]  y;
        logic [11:0] c;
        logic        s;
        logic        d;
    } pix_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        hsync, vsync;
    logic [11:0] rgb;
    logic        pix_valid, frame_start, frame_done, locked, h_err, v_err;
    logic [9:0]  pix_x, pix_y;
    logic [11:0] pix_rgb;
    logic [15:0] frame_sum;
    logic [7:0]  err_count;

    int   checks = 0;
    int   errors = 0;
    pix_t pix_q[$];
    logic [15:0] sum_q[$];

    int   gx = 0, gy = 0;
    int   short_y = -1, short_x = 0, hold_y = -1, jump_y = -1;
    int   color_mode = 0;
    logic exp_h = 1'b0, exp_locked = 1'b0, frame_clean = 1'b0;
    logic [15:0] model_sum = '0, last_sum = '0;
    int   start_seen = 0, done_seen = 0, herr_seen = 0, verr_seen = 0;
    int   run_len = 0, last_x = 0;

    vga_rx_monitor #(
        .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HSW), .H_TOTAL(HT),
        .V_VISIBLE(VV), .V_FRONT(VF), .V_TOTAL(VT), .SYNC_POL(0)
    ) dut (
        .clk_25_175(clk), .rst(rst), .hsync(hsync), .vsync(vsync), .rgb(rgb),
        .pix_valid(pix_valid), .pix_x(pix_x), .pix_y(pix_y), .pix_rgb(pix_rgb),
        .frame_start(frame_start), .frame_done(frame_done), .frame_sum(frame_sum),
        .locked(locked), .h_err(h_err), .v_err(v_err), .err_count(err_count)
    );

    // Free-running pixel clock.
    always #5 clk = ~clk;

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: actual=%0h expected=%0h", tag, actual, expected);
        end
    endtask

    // Drives one sample onto the pins and lets it be clocked in.
    task automatic applyStimulus(input logic h, input logic v, input logic [11:0] c);
        hsync = h;
        vsync = v;
        rgb   = c;
        @(posedge clk);
        #1;
    endtask

    // One generator clock: applies any planted fault, updates the expected
    // lock status from the sync events being driven, queues the expected
    // pixel report, then drives the pins and advances the raster position.
    task automatic stepPixel();
        logic       held, hs_act, vs_act, jumped;
        logic [3:0] n;
        logic [11:0] c;
        pix_t e;
        jumped = 1'b0;
        if (short_y >= 0 && gy == short_y && gx == short_x) begin
            gx = HS;
            exp_locked = 1'b0;
        end
        if (jump_y >= 0 && gx == 0 && gy == jump_y) begin
            gy = VS;
            exp_locked = 1'b0;
            jumped = 1'b1;
        end
        held   = (hold_y >= 0) && (gy >= hold_y) && (gy < hold_y + 2);
        hs_act = !held && (gx >= HS) && (gx < HS + HSW);
        vs_act = (gy >= VS) && (gy < VS + VSW);
        if (gx == HS) begin
            if (held) begin
                exp_h = 1'b0;
                exp_locked = 1'b0;
            end else begin
                exp_h = 1'b1;
            end
        end
        if (gx == 0 && gy == VS && !jumped && exp_h) exp_locked = 1'b1;
        n = 4'(gx);
        case (color_mode)
            0:       c = 12'h001;
            1:       c = {n, n, n};
            default: c = 12'hFFF;
        endcase
        if (gx == 0 && gy == 0) frame_clean = exp_locked;
        else if (!exp_locked) frame_clean = 1'b0;
        if (exp_locked && gx < HV && gy < VV) begin
            model_sum = (gx == 0 && gy == 0) ? {4'b0, c} : model_sum + {4'b0, c};
            e.x = 10'(gx);
            e.y = 10'(gy);
            e.c = c;
            e.s = (gx == 0 && gy == 0);
            e.d = (gx == HV - 1 && gy == VV - 1 && frame_clean);
            pix_q.push_back(e);
            if (e.d) begin
                sum_q.push_back(model_sum);
                last_sum = model_sum;
            end
        end
        applyStimulus(hs_act ? 1'b0 : 1'b1, vs_act ? 1'b0 : 1'b1, c);
        if (gx == HT - 1) begin
            gx = 0;
            gy = (gy == VT - 1) ? 0 : gy + 1;
        end else begin
            gx = gx + 1;
        end
    endtask

    task automatic runUntil(input int x, input int y);
        int budget;
        budget = HT * VT * 2;
        while (!(gx == x && gy == y) && budget > 0) begin
            stepPixel();
            budget--;
        end
        if (budget == 0) checkOutput("run_bound", 1, 0);
    endtask

    task automatic runFrame();
        int budget;
        budget = HT * VT * 2;
        do begin
            stepPixel();
            budget--;
        end while (!(gx == 0 && gy == 0) && budget > 0);
        if (budget == 0) checkOutput("frame_bound", 1, 0);
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_pix"}, {pix_x, pix_y, pix_rgb}, 0);
        checkOutput({tag, "_flags"}, {26'd0, pix_valid, frame_start, frame_done,
                                      locked, h_err, v_err}, 0);
        checkOutput({tag, "_sum_cnt"}, {frame_sum, 8'd0, err_count}, 0);
    endtask

    // Output monitor: pops the scoreboard on every reported pixel, checks
    // idle outputs, line lengths, checksums on frame_done and tallies pulses.
    always @(negedge clk) begin
        pix_t e;
        if (rst) begin
            run_len = 0;
        end else begin
            if (pix_valid) begin
                if (pix_q.size() == 0) begin
                    checkOutput("unexpected_pix", 32'(pix_valid), 0);
                end else begin
                    e = pix_q.pop_front();
                    checkOutput("pix_x", 32'(pix_x), 32'(e.x));
                    checkOutput("pix_y", 32'(pix_y), 32'(e.y));
                    checkOutput("pix_rgb", 32'(pix_rgb), 32'(e.c));
                    checkOutput("frame_start", 32'(frame_start), 32'(e.s));
                    checkOutput("frame_done", 32'(frame_done), 32'(e.d));
                    last_x = int'(e.x);
                end
                run_len++;
            end else begin
                if (run_len != 0 && last_x == HV - 1) checkOutput("line_len", run_len, HV);
                run_len = 0;
                checkOutput("idle_pix", {pix_x, pix_y, pix_rgb}, 0);
                checkOutput("idle_pulse", {30'd0, frame_start, frame_done}, 0);
            end
            if (frame_done) begin
                if (sum_q.size() == 0) checkOutput("unexpected_done", 32'(frame_done), 0);
                else checkOutput("frame_sum", 32'(frame_sum), 32'(sum_q.pop_front()));
            end
            if (frame_start) start_seen++;
            if (frame_done)  done_seen++;
            if (h_err)       herr_seen++;
            if (v_err)       verr_seen++;
        end
    end

    initial begin
        logic [15:0] prev_sum;
        int          herr_base;
        rst = 1'b1;
        repeat (3) applyStimulus(1'b1, 1'b1, 12'h000);
        checkAllZero("reset");
        rst = 1'b0;

        // Frame 0 locks at the vsync fall; frame 1 is the first full frame.
        runUntil(0, VS);
        checkOutput("locked_before_vsync", 32'(locked), 0);
        stepPixel();
        checkOutput("locked_at_vsync", 32'(locked), 1);
        runFrame();
        runFrame();
        checkOutput("f1_starts", start_seen, 1);
        checkOutput("f1_dones", done_seen, 1);
        checkOutput("f1_sum", 32'(frame_sum), 32'(16'(HV * VV)));
        checkOutput("f1_herr", herr_seen, 0);
        checkOutput("f1_verr", verr_seen, 0);
        checkOutput("f1_err_count", 32'(err_count), 0);

        // Gradient frame.
        color_mode = 1;
        runFrame();
        checkOutput("f2_dones", done_seen, 2);
        checkOutput("f2_sum", 32'(frame_sum), 32'(last_sum));

        // Short line while locked.
        prev_sum = last_sum;
        short_y = 5;
        short_x = 12;
        runUntil(12, 5);
        stepPixel();
        checkOutput("short_locked_fall", 32'(locked), 0);
        runFrame();
        short_y = -1;
        checkOutput("short_herr", herr_seen, 1);
        checkOutput("short_err_count", 32'(err_count), 1);
        checkOutput("short_no_done", done_seen, 2);
        checkOutput("short_sum_held", 32'(frame_sum), 32'(prev_sum));
        checkOutput("short_relock", 32'(locked), 1);

        // hsync missing for two lines while locked.
        hold_y = 3;
        runUntil(HS, 3);
        stepPixel();
        checkOutput("hold_unlocked", 32'(locked), 0);
        runFrame();
        hold_y = -1;
        checkOutput("hold_herr", herr_seen, 2);
        checkOutput("hold_err_count", 32'(err_count), 2);
        checkOutput("hold_no_done", done_seen, 2);
        checkOutput("hold_relock", 32'(locked), 1);

        // Misplaced vsync at the start of line 6.
        jump_y = 6;
        runUntil(0, 6);
        stepPixel();
        checkOutput("jump_unlocked", 32'(locked), 0);
        runFrame();
        jump_y = -1;
        checkOutput("jump_verr", verr_seen, 1);
        checkOutput("jump_herr", herr_seen, 2);
        checkOutput("jump_err_count", 32'(err_count), 3);
        checkOutput("jump_still_unlocked", 32'(locked), 0);
        runUntil(0, VS);
        checkOutput("jump_pre_relock", 32'(locked), 0);
        stepPixel();
        checkOutput("jump_relock", 32'(locked), 1);
        runFrame();

        // Reset in the middle of a locked frame.
        runUntil(8, 6);
        rst = 1'b1;
        pix_q.delete();
        exp_h = 1'b0;
        exp_locked = 1'b0;
        frame_clean = 1'b0;
        repeat (3) stepPixel();
        checkAllZero("mid_reset");
        rst = 1'b0;
        runFrame();
        checkOutput("rst_relock", 32'(locked), 1);
        checkOutput("rst_err_count", 32'(err_count), 0);

        // Clean frame of full-scale colour exercises checksum wrap.
        color_mode = 2;
        runFrame();
        checkOutput("f8_dones", done_seen, 3);
        checkOutput("f8_sum", 32'(frame_sum), 32'(last_sum));

        // Repeated misplaced hsync falls: one error per fall, saturating.
        herr_base = herr_seen;
        for (int i = 0; i < 300; i++) begin
            applyStimulus(1'b0, 1'b1, 12'h000);
            applyStimulus(1'b0, 1'b1, 12'h000);
            applyStimulus(1'b1, 1'b1, 12'h000);
            applyStimulus(1'b1, 1'b1, 12'h000);
            if (i == 99) checkOutput("sat_count_100", 32'(err_count), 100);
        end
        checkOutput("sat_count", 32'(err_count), 255);
        checkOutput("sat_herr_pulses", herr_seen - herr_base, 300);
        checkOutput("sat_unlocked", 32'(locked), 0);

        checkOutput("pix_queue_empty", pix_q.size(), 0);
        checkOutput("sum_queue_empty", sum_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/vga_rx_monitor.md
Name: vga_rx_monitor

Overview:
- Receive-side counterpart of the screensaver VGA output. Samples hsync, vsync and 12-bit RGB at the pixel clock and locks its own counters to the sync edges.
- Reports the pixel coordinates and colour of each visible pixel, checks the 640x480@60 timing, and computes a per-frame colour checksum.
- Used in the test harness and on-chip loopback to verify the generator's output.

Parameters:
- H_VISIBLE, 640, visible pixels per line
- H_FRONT, 16, horizontal front porch
- H_SYNC, 96, hsync width (informational; width not checked)
- H_TOTAL, 800, clocks per line
- V_VISIBLE, 480, visible lines
- V_FRONT, 10, vertical front porch
- V_TOTAL, 525, lines per frame
- SYNC_POL, 0, active sync level (0 = active-low)

Ports:
- clk_25_175  in  1  pixel clock
- rst  in  1  asynchronous reset, active-high
- hsync  in  1  horizontal sync from generator
- vsync  in  1  vertical sync from generator
- rgb  in  12  {r,g,b}, 4 bits each
- pix_valid  out  1  pix_* outputs hold a visible pixel
- pix_x  out  10  column 0..H_VISIBLE-1
- pix_y  out  10  row 0..V_VISIBLE-1
- pix_rgb  out  12  captured colour
- frame_start  out  1  pulse with pixel (0,0)
- frame_done  out  1  pulse with last visible pixel of a clean frame
- frame_sum  out  16  checksum of last clean frame
- locked  out  1  state == LOCKED
- h_err  out  1  1-cycle horizontal timing error pulse
- v_err  out  1  1-cycle vertical timing error pulse
- err_count  out  8  saturating error count

Behaviour:
- Reset: every output = 0; state = SEARCH; counters = 0. Reset mid-frame aborts everything; relock requires new sync edges.
- Stage 1 registers hsync, vsync and rgb. Counters hc (0..H_TOTAL-1) and vc (0..V_TOTAL-1) index the stage-1 sample. Stage 2 registers all pix_*, frame_*, h_err and v_err.
- Latency: 2 clocks from input pins to outputs.
- Edge definition: a sync "fall" is the transition of the stage-1 sync from inactive to active (active level set by SYNC_POL).
- Natural count: hc increments and wraps H_TOTAL-1 -> 0. vc increments on each hc wrap and wraps V_TOTAL-1 -> 0.
- HS = H_VISIBLE+H_FRONT (656); VS = V_VISIBLE+V_FRONT (490).
- hsync fall: hc is loaded with HS for that sample.
- vsync fall: vc is loaded with VS. It must coincide with the sample whose natural hc is 0.
- States:
  - SEARCH: counters free-run; no checks. hsync fall -> HLOCK.
  - HLOCK: horizontal checks active. vsync fall with natural hc == 0 -> LOCKED.
  - LOCKED: horizontal and vertical checks active; pix_valid allowed.
- h_err conditions (HLOCK or LOCKED):
  - hsync fall when natural hc != HS: pulse h_err, reload hc; LOCKED -> HLOCK; HLOCK stays HLOCK.
  - natural hc reaches HS with no fall: pulse h_err, go to SEARCH.
- v_err conditions (LOCKED):
  - vsync fall when natural (hc,vc) != (0,VS): pulse v_err, reload vc, go to HLOCK.
  - natural (hc,vc) reaches (0,VS) with no fall: pulse v_err, go to HLOCK.
- A vsync fall with natural hc != 0 in HLOCK is ignored; state stays HLOCK.
- Simultaneous h_err and v_err: both pulse; the more severe transition wins (SEARCH > HLOCK).
- err_count: +1 per cycle in which h_err or v_err pulses (not +2 for a simultaneous pair); saturates at 255.
- Output qualification:
  - pix_valid = LOCKED && hc < H_VISIBLE && vc < V_VISIBLE.
  - pix_x, pix_y, pix_rgb are driven only when pix_valid; otherwise held at 0.
  - frame_start pulses with pix_valid at (0,0).
- Checksum:
  - Accumulator is cleared at (0,0) and adds zero-extended rgb for each valid pixel, mod 2^16.
  - A frame is clean if the state was LOCKED continuously from its frame_start through (H_VISIBLE-1, V_VISIBLE-1).
  - On a clean frame, frame_done pulses with that last pixel and frame_sum updates the same cycle, including that pixel.
  - On an unclean frame, frame_sum holds its previous value.

Test Plan:
- Reset, then two nominal frames of constant rgb=12'h001, syncs active-low:
  - locked rises at the first vsync fall.
  - frame_start and frame_done each pulse once in the second frame; frame_sum = 16'hB000; h_err, v_err and err_count stay 0.
- Gradient rgb = x[3:0] replicated into r, g and b:
  - pix_x/pix_y match the generator coordinates; pix_rgb matches the input delayed 2 clocks; pix_valid high for exactly 640 clocks per visible line.
- Short line (hsync fall at natural hc 600) while LOCKED:
  - h_err pulses once; err_count = 1; locked falls.
  - No frame_done that frame; frame_sum keeps its previous value; relock at next vsync.
- hsync held inactive for 2 lines while LOCKED:
  - h_err pulses when hc reaches 656; state = SEARCH; pix_valid stays 0.
  - Relocks after the next hsync fall plus vsync fall.
- vsync fall at hc 0 of line 300:
  - v_err pulses; vc = 490; locked stays 0 until the next correctly placed vsync.
- rst asserted mid-frame at (320,200):
  - All outputs are 0 during reset. After release, no pix_valid until hsync fall and vsync fall are both seen.
  - err_count saturation check: 300 forced errors -> err_count = 255.
